// File: rtl/npn_tt_capture_if.sv
// Signal bundle between the truth-table capture block and the bench that drives
// start/tt_exp and closes the loop from x_out back to y_in through a netlist.
interface npn_tt_capture_if;
    logic        start;
    logic [15:0] tt_exp;
    logic [3:0]  x_out;
    logic        y_in;
    logic        busy;
    logic        done;
    logic [15:0] tt;
    logic [4:0]  ones;
    logic        match;
    logic        out_neg;

    modport slave (
        input  start, tt_exp, y_in,
        output x_out, busy, done, tt, ones, match, out_neg
    );

    modport master (
        output start, tt_exp, y_in,
        input  x_out, busy, done, tt, ones, match, out_neg
    );
endinterface

// File: rtl/npn_tt_capture.sv
// Walks minterms 0..15 onto a 4-input netlist and rebuilds its 16-bit truth table.
// Optional output normalisation (complement when popcount > 8) under NPN_TT_OUTNORM_EN.
module npn_tt_capture #(
    parameter int unsigned SETTLE_CYCLES = 0,
    parameter int unsigned CNT_W         = 4
) (
    input  logic           clk,
    input  logic           rst,
    npn_tt_capture_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [1:0]       state_r;
    logic [3:0]       m_r;
    logic [CNT_W-1:0] cnt_r;
    logic [15:0]      exp_r;
    logic [15:0]      tt_r;
    logic [4:0]       ones_r;
    logic             match_r;
    logic             out_neg_r;
    logic             busy_r;
    logic             done_r;
    logic [3:0]       x_out_r;

    logic [15:0]      full_s;
    logic [4:0]       raw_ones_s;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] s;
        s = 5'd0;
        for (int i = 0; i < 16; i++) begin
            s = s + {4'd0, v[i]};
        end
        return s;
    endfunction

    // Table as it will look once the current minterm's sample is written in.
    always_comb begin
        full_s        = tt_r;
        full_s[m_r]   = bus.y_in;
        raw_ones_s    = popcount16(full_s);
    end

    // Capture sequencer; FIN behaves like IDLE so a start in the done cycle is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            m_r       <= 4'd0;
            cnt_r     <= '0;
            exp_r     <= 16'd0;
            tt_r      <= 16'd0;
            ones_r    <= 5'd0;
            match_r   <= 1'b0;
            out_neg_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            x_out_r   <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_FIN: begin
                    done_r  <= 1'b0;
                    x_out_r <= 4'd0;
                    if (bus.start) begin
                        exp_r     <= bus.tt_exp;
                        tt_r      <= 16'd0;
                        ones_r    <= 5'd0;
                        match_r   <= 1'b0;
                        out_neg_r <= 1'b0;
                        m_r       <= 4'd0;
                        cnt_r     <= CNT_RELOAD;
                        busy_r    <= 1'b1;
                        state_r   <= ST_HOLD;
                    end else begin
                        busy_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (cnt_r != '0) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else begin
                        tt_r <= full_s;
                        if (m_r != 4'd15) begin
                            m_r     <= m_r + 4'd1;
                            x_out_r <= m_r + 4'd1;
                            cnt_r   <= CNT_RELOAD;
                        end else begin
                            state_r <= ST_FIN;
                            busy_r  <= 1'b0;
                            x_out_r <= 4'd0;
                            done_r  <= 1'b1;
                            match_r <= (full_s == exp_r);
`ifdef NPN_TT_OUTNORM_EN
                            if (raw_ones_s > 5'd8) begin
                                tt_r      <= ~full_s;
                                ones_r    <= 5'd16 - raw_ones_s;
                                out_neg_r <= 1'b1;
                            end else begin
                                ones_r    <= raw_ones_s;
                                out_neg_r <= 1'b0;
                            end
`else
                            ones_r    <= raw_ones_s;
                            out_neg_r <= 1'b0;
`endif
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    x_out_r <= 4'd0;
                end
            endcase
        end
    end

    assign bus.x_out   = x_out_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.tt      = tt_r;
    assign bus.ones    = ones_r;
    assign bus.match   = match_r;
    assign bus.out_neg = out_neg_r;

endmodule

// File: tb/tb_npn_tt_capture.sv
// Directed bench for npn_tt_capture: one instance with no settle cycles, one with two.
module tb_npn_tt_capture;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   mode   = 0;

    npn_tt_capture_if if0();
    npn_tt_capture_if if2();

    // mode 0: x0, 1: AND, 2: x1^x3, 3: NAND
    function automatic logic yfn(input int md, input logic [3:0] x);
        case (md)
            0:       return x[0];
            1:       return &x;
            2:       return x[1] ^ x[3];
            3:       return ~(&x);
            default: return 1'b0;
        endcase
    endfunction

    assign if0.y_in = yfn(mode, if0.x_out);
    assign if2.y_in = yfn(mode, if2.x_out);

    npn_tt_capture #(.SETTLE_CYCLES(0), .CNT_W(4)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    npn_tt_capture #(.SETTLE_CYCLES(2), .CNT_W(4)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller raises start at a negedge; this waits E0 then watches ncyc cycles.
    task automatic run_capture(input int which, input int ncyc, output int lat, output int busy_n,
                               output int done_n, output logic [3:0] xo3, output logic [3:0] xo4);
        logic       b;
        logic       d;
        logic [3:0] x;
        lat = 0; busy_n = 0; done_n = 0; xo3 = 4'hF; xo4 = 4'hF;
        @(posedge clk);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (which == 0) begin
                if0.start = 1'b0;
                b = if0.busy; d = if0.done; x = if0.x_out;
            end else begin
                if2.start = 1'b0;
                b = if2.busy; d = if2.done; x = if2.x_out;
            end
            if (b) busy_n++;
            if (d) begin
                done_n++;
                if (lat == 0) lat = k;
            end
            if (k == 3) xo3 = x;
            if (k == 4) xo4 = x;
        end
    endtask

    initial begin
        int         lat;
        int         bn;
        int         dn;
        int         pulsed;
        int         found;
        logic [3:0] xo3;
        logic [3:0] xo4;

        rst = 1'b1;
        if0.start = 1'b0; if0.tt_exp = 16'd0;
        if2.start = 1'b0; if2.tt_exp = 16'd0;
        #12;
        chk("rst_busy",    32'(if0.busy),    32'd0);
        chk("rst_done",    32'(if0.done),    32'd0);
        chk("rst_x_out",   32'(if0.x_out),   32'd0);
        chk("rst_tt",      32'(if0.tt),      32'd0);
        chk("rst_ones",    32'(if0.ones),    32'd0);
        chk("rst_match",   32'(if0.match),   32'd0);
        chk("rst_out_neg", 32'(if0.out_neg), 32'd0);
        chk("rst_busy2",   32'(if2.busy),    32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: y = x0, expect AAAA, 16-cycle latency
        @(negedge clk);
        mode = 0; if0.tt_exp = 16'hAAAA; if0.start = 1'b1;
        run_capture(0, 22, lat, bn, dn, xo3, xo4);
        chk("t1_latency", 32'(lat), 32'd17);
        chk("t1_busy_cycles", 32'(bn), 32'd16);
        chk("t1_done_pulses", 32'(dn), 32'd1);
        chk("t1_tt",      32'(if0.tt),      32'h0000_AAAA);
        chk("t1_ones",    32'(if0.ones),    32'd8);
        chk("t1_match",   32'(if0.match),   32'd1);
        chk("t1_out_neg", 32'(if0.out_neg), 32'd0);
        chk("t1_x_out",   32'(if0.x_out),   32'd0);

        // 2: AND, mismatching expectation
        mode = 1; if0.tt_exp = 16'h8001; if0.start = 1'b1;
        run_capture(0, 22, lat, bn, dn, xo3, xo4);
        chk("t2_latency", 32'(lat),       32'd17);
        chk("t2_tt",      32'(if0.tt),    32'h0000_8000);
        chk("t2_ones",    32'(if0.ones),  32'd1);
        chk("t2_match",   32'(if0.match), 32'd0);

        // 3: settle 2, y = x1^x3
        mode = 2; if2.tt_exp = 16'h33CC; if2.start = 1'b1;
        run_capture(2, 55, lat, bn, dn, xo3, xo4);
        chk("t3_latency", 32'(lat), 32'd49);
        chk("t3_busy_cycles", 32'(bn), 32'd48);
        chk("t3_done_pulses", 32'(dn), 32'd1);
        chk("t3_hold_m0", 32'(xo3), 32'd0);
        chk("t3_step_m1", 32'(xo4), 32'd1);
        chk("t3_tt",      32'(if2.tt),    32'h0000_33CC);
        chk("t3_ones",    32'(if2.ones),  32'd8);
        chk("t3_match",   32'(if2.match), 32'd1);

        // 4: start re-pulsed mid-capture with a different expectation
        mode = 0; if0.tt_exp = 16'hAAAA; if0.start = 1'b1;
        @(posedge clk);
        lat = 0; dn = 0; pulsed = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if0.start = 1'b0;
            if (pulsed == 0 && if0.x_out == 4'd5) begin
                if0.start = 1'b1; if0.tt_exp = 16'h5555; pulsed = 1;
            end
            if (if0.done) begin
                dn++;
                if (lat == 0) lat = k;
            end
        end
        chk("t4_pulsed",  32'(pulsed), 32'd1);
        chk("t4_latency", 32'(lat),    32'd17);
        chk("t4_done_pulses", 32'(dn), 32'd1);
        chk("t4_tt",      32'(if0.tt),    32'h0000_AAAA);
        chk("t4_match",   32'(if0.match), 32'd1);

        // 5: reset while x_out = 7
        mode = 0; if0.tt_exp = 16'hAAAA; if0.start = 1'b1;
        @(posedge clk);
        found = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if0.start = 1'b0;
            if (if0.x_out == 4'd7) begin
                found = 1;
                break;
            end
        end
        chk("t5_reached_7", 32'(found), 32'd1);
        chk("t5_partial_tt", 32'(if0.tt), 32'h0000_002A);
        chk("t5_busy_before", 32'(if0.busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("t5_busy",  32'(if0.busy),  32'd0);
        chk("t5_x_out", 32'(if0.x_out), 32'd0);
        chk("t5_tt",    32'(if0.tt),    32'd0);
        chk("t5_done",  32'(if0.done),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (if0.done) dn++;
        end
        chk("t5_no_done", 32'(dn), 32'd0);

        // 6: NAND after reset, full walk
        mode = 3; if0.tt_exp = 16'h7FFF; if0.start = 1'b1;
        run_capture(0, 22, lat, bn, dn, xo3, xo4);
        chk("t6_latency", 32'(lat), 32'd17);
        chk("t6_busy_cycles", 32'(bn), 32'd16);
        chk("t6_done_pulses", 32'(dn), 32'd1);
        chk("t6_match", 32'(if0.match), 32'd1);
`ifdef NPN_TT_OUTNORM_EN
        chk("t6_tt",      32'(if0.tt),      32'h0000_8000);
        chk("t6_ones",    32'(if0.ones),    32'd1);
        chk("t6_out_neg", 32'(if0.out_neg), 32'd1);
`else
        chk("t6_tt",      32'(if0.tt),      32'h0000_7FFF);
        chk("t6_ones",    32'(if0.ones),    32'd15);
        chk("t6_out_neg", 32'(if0.out_neg), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/npn_tt_capture.md
Name: npn_tt_capture

Overview:
- Sequential truth-table reader for the 4-input single-output exact-synthesis netlists in this library.
- On a start pulse it walks all 16 input minterms onto a netlist under test and samples its y0 output once per minterm. It assembles the 16-bit truth table, reports its popcount, and compares it against an expected table.
- Sits in the bench/self-check harness on the opposite side of the combinational netlists: they map inputs to y0, this block maps y0 back to a truth table.

Parameters:
- SETTLE_CYCLES, 0, extra cycles each minterm is held before y_in is sampled. Legal range 0..15.
- CNT_W, 4, width of the settle counter. Must hold SETTLE_CYCLES.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a capture. Accepted only while busy=0.
- tt_exp  input  16  expected truth table, latched at accepted start.
- x_out  output  4  minterm driven to the netlist. Bit i drives input xi.
- y_in  input  1  netlist output y0.
- busy  output  1  high from the accepted start edge until the final sample edge.
- done  output  1  one-cycle pulse: results valid.
- tt  output  16  captured table. tt[m] = y0 for minterm m = {x3,x2,x1,x0}.
- ones  output  5  popcount of tt, 0..16.
- match  output  1  captured table equals latched tt_exp.
- out_neg  output  1  output-negation flag (see Optional Feature).

Behaviour:
- Reset (async, any state, including mid-capture):
  - Outputs: busy=0, done=0, x_out=0, tt=0, ones=0, match=0, out_neg=0.
  - Internal: FSM=IDLE, counters=0, latched expected table=0.
- FSM states: IDLE, HOLD, FIN.
- IDLE:
  - x_out=0, busy=0.
  - On start=1 at edge E0: latch tt_exp; clear tt, ones, match, out_neg; minterm index m=0; settle counter=SETTLE_CYCLES; go to HOLD; busy=1.
- HOLD:
  - x_out=m, registered and glitch-free.
  - Each edge with counter>0 decrements the counter.
  - At the edge where counter==0:
    - write tt[m] <= y_in;
    - if m<15: m <= m+1 and counter reloads to SETTLE_CYCLES;
    - if m==15: go to FIN.
  - Each minterm is held exactly SETTLE_CYCLES+1 cycles.
  - Sample of minterm m occurs at edge E0+(SETTLE_CYCLES+1)*(m+1).
- FIN entry edge, i.e. the 16th sample edge E0+16*(SETTLE_CYCLES+1):
  - busy=0 and x_out=0;
  - ones, match and out_neg registered from the complete table (including the bit just sampled);
  - done=1 for exactly one cycle;
  - return to IDLE next edge.
- Latency: done is high in the cycle following edge E0+16*(SETTLE_CYCLES+1).
  - SETTLE_CYCLES=0 gives 16 cycles.
- Results hold: tt, ones, match and out_neg remain stable until the next accepted start or reset.
- start rules:
  - start while busy=1 is ignored, with no effect on the capture in progress.
  - start in the done cycle is accepted (busy=0 there).
  - tt_exp changes after the start edge do not affect match.
- Index handling: m is 4-bit, never wraps mid-capture; the walk stops at 15.
- y_in is sampled only at sample edges. Changes in other cycles are ignored.
- match uses the raw captured table in all builds.

Optional Feature:
- Macro: NPN_TT_OUTNORM_EN.
- Defined: at the FIN entry edge, if raw popcount > 8:
  - tt presents the bitwise complement of the raw table;
  - ones = 16 - raw popcount;
  - out_neg = 1.
  - Otherwise tt is raw and out_neg=0.
  - Popcount exactly 8 is not complemented.
  - During HOLD, tt shows raw partial bits.
- Not defined:
  - tt is always raw;
  - ones is the raw popcount;
  - out_neg is tied to 0.

Test Plan:
1. SETTLE_CYCLES=0, bench drives y_in=x_out[0], tt_exp=16'hAAAA, start at E0 -> tt=16'hAAAA, ones=8, match=1; done high exactly in the cycle after E0+16; busy high 16 cycles.
2. SETTLE_CYCLES=0, y_in = AND of x_out, tt_exp=16'h8001 -> tt=16'h8000, ones=1, match=0.
3. SETTLE_CYCLES=2, y_in = x_out[1]^x_out[3], tt_exp=16'h33CC -> each x_out value held 3 cycles; done in the cycle after E0+48; tt=16'h33CC, ones=8, match=1.
4. start pulsed again while x_out=5 mid-capture, with a different tt_exp -> capture continues unchanged; single done; match evaluated against the original tt_exp.
5. rst asserted while x_out=7 -> same cycle: busy=0, x_out=0, tt=0, done never pulses. A new start afterward completes normally with a full 16-minterm walk.
6. y_in = NAND of x_out, tt_exp=16'h7FFF:
   - with NPN_TT_OUTNORM_EN -> tt=16'h8000, ones=1, out_neg=1, match=1;
   - without -> tt=16'h7FFF, ones=15, out_neg=0, match=1.
